// File: rtl/chan_scan_arbiter_if.sv
// Bundle of the channel-side and stream-side signals of the readout sequencer.
// Latency: none (wires only).
// Backpressure: carries out_valid/out_ready; master = sequencer, slave = environment.
interface chan_scan_arbiter_if #(
  parameter int N_INPUTS    = 8,
  parameter int INPUT_WIDTH = 22,
  parameter int SEL_WIDTH   = 5
);
  logic [N_INPUTS-1:0]    req;
  logic [INPUT_WIDTH-1:0] mux_data;
  logic [SEL_WIDTH-1:0]   sel;
  logic [N_INPUTS-1:0]    ack;
  logic                   out_valid;
  logic                   out_ready;
  logic [INPUT_WIDTH-1:0] out_data;
  logic [SEL_WIDTH-1:0]   out_chan;

  modport master (
    input  req, mux_data, out_ready,
    output sel, ack, out_valid, out_data, out_chan
  );

  modport slave (
    output req, mux_data, out_ready,
    input  sel, ack, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/chan_scan_arbiter.sv
// Round-robin readout sequencer: steers the mux select, captures the word after settle, streams it out.
// Latency: req seen in IDLE at t -> sel at t+1 -> out_valid/ack at t+1+SETTLE_CYCLES.
// Backpressure: word held stable in OUT until out_valid&out_ready; no new scan starts meanwhile.
// Optional: define CHAN_SCAN_TAG_EN to register the granted channel index on out_chan.
module chan_scan_arbiter #(
  parameter int N_INPUTS      = 8,
  parameter int INPUT_WIDTH   = 22,
  parameter int SEL_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chan_scan_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

  localparam logic [N_INPUTS-1:0]  ACK_LSB  = N_INPUTS'(1);
  localparam logic [SEL_WIDTH-1:0] LAST_CH  = SEL_WIDTH'(N_INPUTS - 1);
  localparam logic [3:0]           CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]   ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [N_INPUTS-1:0]    ack_q, ack_d;
  logic                   out_valid_q, out_valid_d;
  logic [INPUT_WIDTH-1:0] out_data_q, out_data_d;

  logic                   hi_vld, any_vld;
  logic [SEL_WIDTH-1:0]   hi_idx, any_idx, grant;

  // Round-robin pick: lowest requester at or above ptr, else wrap to lowest requester overall.
  always_comb begin
    hi_vld  = 1'b0;
    any_vld = 1'b0;
    hi_idx  = '0;
    any_idx = '0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        any_vld = 1'b1;
        any_idx = SEL_WIDTH'(i);
        if (i >= int'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = SEL_WIDTH'(i);
        end
      end
    end
    grant = hi_vld ? hi_idx : any_idx;
  end

`ifdef CHAN_SCAN_TAG_EN
  logic [SEL_WIDTH-1:0] out_chan_q, out_chan_d;
`endif

  // Next-state and next-output logic of the scan FSM; sel doubles as the held grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    ack_d       = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef CHAN_SCAN_TAG_EN
    out_chan_d  = out_chan_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          sel_d   = grant;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          out_data_d  = bus.mux_data;
          ack_d       = ACK_LSB << sel_q;
          out_valid_d = 1'b1;
          ptr_d       = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
`ifdef CHAN_SCAN_TAG_EN
          out_chan_d  = sel_q;
`endif
          state_d     = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and all registered outputs; reset drops any word in flight without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sel_q       <= '0;
      ack_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef CHAN_SCAN_TAG_EN
  // Channel tag register, loaded together with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_chan_q <= '0;
    else        out_chan_q <= out_chan_d;
  end
  assign bus.out_chan = out_chan_q;
`else
  assign bus.out_chan = '0;
`endif

  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule
